// File: rtl/note_lane_engine.sv
// Falling-note game state: spawns, advances and judges notes in up to NUM_SLOTS slots,
// keeps score/combo, and streams one draw descriptor per live note on request.
module note_lane_engine #(
  parameter int NUM_SLOTS  = 8,
  parameter int TICK_DIV   = 15000000,
  parameter int SPAWN_Y    = 0,
  parameter int HIT_Y      = 110,
  parameter int HIT_WIN    = 4,
  parameter int LANE0_X    = 60,
  parameter int LANE_PITCH = 10
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  key_n,
  input  logic        spawn_valid,
  input  logic [1:0]  spawn_lane,
  output logic        spawn_ready,
  input  logic        frame_start,
  output logic        note_valid,
  input  logic        note_ready,
  output logic [7:0]  note_x,
  output logic [7:0]  note_y,
  output logic [2:0]  note_color,
  output logic        frame_done,
  output logic        hit,
  output logic        miss,
  output logic [15:0] score,
  output logic [7:0]  combo
);

  localparam int IDX_W  = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1;
  localparam int TCNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [7:0]           WIN_LO   = 8'(HIT_Y - HIT_WIN);
  localparam logic [7:0]           WIN_HI   = 8'(HIT_Y + HIT_WIN);
  localparam logic [TCNT_W-1:0]    TCNT_MAX = TCNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0]     IDX_LAST = IDX_W'(NUM_SLOTS - 1);
  localparam logic [NUM_SLOTS-1:0] ONE_SLOT = NUM_SLOTS'(1);

  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_SEND} scan_state_t;

  logic [NUM_SLOTS-1:0] r_active;
  logic [1:0]           r_lane [NUM_SLOTS];
  logic [7:0]           r_y    [NUM_SLOTS];
  logic [3:0]           r_key_q;
  logic [3:0]           r_key_prev;
  logic [TCNT_W-1:0]    r_tcnt;
  logic [15:0]          r_score;
  logic [7:0]           r_combo;
  logic                 r_hit;
  logic                 r_miss;
  scan_state_t          r_state;
  logic [IDX_W-1:0]     r_idx;
  logic                 r_note_valid;
  logic [7:0]           r_note_x;
  logic [7:0]           r_note_y;
  logic [2:0]           r_note_color;
  logic                 r_frame_done;

  logic                          w_tick;
  logic [3:0]                    w_press;
  logic [3:0][NUM_SLOTS-1:0]     w_cand;
  logic [3:0][NUM_SLOTS-1:0]     w_lane_hit;
  logic [3:0]                    w_lane_any;
  logic [NUM_SLOTS-1:0]          w_in_win;
  logic [NUM_SLOTS-1:0]          w_miss_slot;
  logic [NUM_SLOTS-1:0]          w_hit_mask;
  logic [NUM_SLOTS-1:0]          w_free;
  logic [NUM_SLOTS-1:0]          w_spawn_mask;
  logic [7:0]                    w_y_inc [NUM_SLOTS];
  logic [2:0]                    w_hit_cnt;
  logic [8:0]                    w_combo_sum;
  logic                          w_idx_last;

  function automatic logic [7:0] lane_x(input logic [1:0] lane);
    return 8'(LANE0_X + LANE_PITCH * int'(lane));
  endfunction

  function automatic logic [2:0] lane_color(input logic [1:0] lane);
    case (lane)
      2'd0:    return 3'b100;
      2'd1:    return 3'b010;
      2'd2:    return 3'b001;
      default: return 3'b101;
    endcase
  endfunction

  assign w_tick = (r_tcnt == TCNT_MAX);

  generate
    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_slot
      assign w_in_win[gi]    = (r_y[gi] >= WIN_LO) && (r_y[gi] <= WIN_HI);
      assign w_y_inc[gi]     = r_y[gi] + 8'd1;
      assign w_miss_slot[gi] = r_active[gi] & ~w_hit_mask[gi] & w_tick & (w_y_inc[gi] > WIN_HI);
    end

    // Key bit 3 is lane 0; each lane claims its lowest-index in-window candidate.
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign w_press[gi] = r_key_prev[3-gi] & ~r_key_q[3-gi];
      for (genvar gs = 0; gs < NUM_SLOTS; gs++) begin : g_cand
        assign w_cand[gi][gs] = w_press[gi] & r_active[gs] & (r_lane[gs] == 2'(gi)) & w_in_win[gs];
      end
      assign w_lane_hit[gi] = w_cand[gi] & (~w_cand[gi] + ONE_SLOT);
      assign w_lane_any[gi] = |w_cand[gi];
    end
  endgenerate

  assign w_hit_mask = w_lane_hit[0] | w_lane_hit[1] | w_lane_hit[2] | w_lane_hit[3];

  always_comb begin
    w_hit_cnt = 3'd0;
    for (int l = 0; l < 4; l++) begin
      w_hit_cnt = w_hit_cnt + {2'b00, w_lane_any[l]};
    end
  end

  assign w_free       = ~r_active;
  assign spawn_ready  = |w_free;
  assign w_spawn_mask = spawn_valid ? (w_free & (~w_free + ONE_SLOT)) : '0;
  assign w_combo_sum  = {1'b0, r_combo} + 9'(w_hit_cnt);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_active   <= '0;
      r_key_q    <= 4'hF;
      r_key_prev <= 4'hF;
      r_tcnt     <= '0;
      r_score    <= 16'd0;
      r_combo    <= 8'd0;
      r_hit      <= 1'b0;
      r_miss     <= 1'b0;
      for (int s = 0; s < NUM_SLOTS; s++) begin
        r_lane[s] <= 2'd0;
        r_y[s]    <= 8'd0;
      end
    end else begin
      r_key_q    <= key_n;
      r_key_prev <= r_key_q;
      r_tcnt     <= w_tick ? '0 : r_tcnt + 1'b1;
      // Spawn only targets slots inactive in registered state, so it never collides with hit/advance.
      for (int s = 0; s < NUM_SLOTS; s++) begin
        if (w_spawn_mask[s]) begin
          r_active[s] <= 1'b1;
          r_lane[s]   <= spawn_lane;
          r_y[s]      <= 8'(SPAWN_Y);
        end else if (w_hit_mask[s]) begin
          r_active[s] <= 1'b0;
        end else if (r_active[s] && w_tick) begin
          r_y[s] <= w_y_inc[s];
          if (w_miss_slot[s]) r_active[s] <= 1'b0;
        end
      end
      r_score <= r_score + 16'(w_hit_cnt);
      r_hit   <= (w_hit_cnt != 3'd0);
      r_miss  <= |w_miss_slot;
      if (|w_miss_slot)              r_combo <= 8'd0;
      else if (w_combo_sum > 9'd255) r_combo <= 8'd255;
      else                           r_combo <= w_combo_sum[7:0];
    end
  end

  assign w_idx_last = (r_idx == IDX_LAST);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_note_valid <= 1'b0;
      r_note_x     <= 8'd0;
      r_note_y     <= 8'd0;
      r_note_color <= 3'd0;
      r_frame_done <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (frame_start) begin
            r_state <= S_SCAN;
            r_idx   <= '0;
          end
        end
        S_SCAN: begin
          if (r_active[r_idx]) begin
            r_note_x     <= lane_x(r_lane[r_idx]);
            r_note_y     <= r_y[r_idx];
            r_note_color <= lane_color(r_lane[r_idx]);
            r_note_valid <= 1'b1;
            r_state      <= S_SEND;
          end else if (w_idx_last) begin
            r_frame_done <= 1'b1;
            r_state      <= S_IDLE;
            r_idx        <= '0;
          end else begin
            r_idx <= r_idx + 1'b1;
          end
        end
        S_SEND: begin
          if (note_ready) begin
            r_note_valid <= 1'b0;
            if (w_idx_last) begin
              r_frame_done <= 1'b1;
              r_state      <= S_IDLE;
              r_idx        <= '0;
            end else begin
              r_idx   <= r_idx + 1'b1;
              r_state <= S_SCAN;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign note_valid = r_note_valid;
  assign note_x     = r_note_x;
  assign note_y     = r_note_y;
  assign note_color = r_note_color;
  assign frame_done = r_frame_done;
  assign hit        = r_hit;
  assign miss       = r_miss;
  assign score      = r_score;
  assign combo      = r_combo;

endmodule

// File: tb/tb_note_lane_engine.sv
// Bench for note_lane_engine: directed scenarios plus a random soak, every cycle
// checked against a note-list reference model.
module tb_note_lane_engine;
  localparam int NS = 8;
  localparam int TD = 4;
  localparam int LO = 106;
  localparam int HI = 114;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  key_n = 4'hF;
  logic        spawn_valid = 1'b0;
  logic [1:0]  spawn_lane = 2'd0;
  logic        spawn_ready;
  logic        frame_start = 1'b0;
  logic        note_valid;
  logic        note_ready = 1'b0;
  logic [7:0]  note_x, note_y;
  logic [2:0]  note_color;
  logic        frame_done, hit, miss;
  logic [15:0] score;
  logic [7:0]  combo;

  always #5 clock = ~clock;

  note_lane_engine #(.NUM_SLOTS(NS), .TICK_DIV(TD)) dut (
    .clock(clock), .reset(reset), .key_n(key_n),
    .spawn_valid(spawn_valid), .spawn_lane(spawn_lane), .spawn_ready(spawn_ready),
    .frame_start(frame_start), .note_valid(note_valid), .note_ready(note_ready),
    .note_x(note_x), .note_y(note_y), .note_color(note_color),
    .frame_done(frame_done), .hit(hit), .miss(miss), .score(score), .combo(combo)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a plain list of notes plus a descriptor cursor.
  bit m_ok = 1'b0;
  int m_act[NS], m_lane[NS], m_y[NS];
  bit [3:0] m_kq, m_kp;
  int m_tcnt, m_score, m_combo;
  bit m_hit, m_miss;
  int m_st, m_idx;
  bit m_nv, m_fd;
  int m_nx, m_ny, m_nc;
  bit mp[4];
  int mhitm[NS];
  int mhits, mmiss, mfree;
  bit mtick, mfound, madv;

  function automatic int lane_x(input int l);
    return 60 + 10 * l;
  endfunction

  function automatic int lane_col(input int l);
    case (l)
      0: return 4;
      1: return 2;
      2: return 1;
      default: return 5;
    endcase
  endfunction

  function automatic int any_free();
    for (int s = 0; s < NS; s++) if (m_act[s] == 0) return 1;
    return 0;
  endfunction

  always @(posedge clock) begin
    if (reset) begin
      for (int s = 0; s < NS; s++) begin m_act[s] = 0; m_lane[s] = 0; m_y[s] = 0; end
      m_kq = 4'hF; m_kp = 4'hF; m_tcnt = 0; m_score = 0; m_combo = 0;
      m_hit = 0; m_miss = 0; m_st = 0; m_idx = 0; m_nv = 0; m_fd = 0;
      m_nx = 0; m_ny = 0; m_nc = 0; m_ok = 1'b1;
    end else begin
      for (int l = 0; l < 4; l++) mp[l] = m_kp[3-l] && !m_kq[3-l];
      mtick = (m_tcnt == TD - 1);
      mhits = 0; mmiss = 0;
      for (int s = 0; s < NS; s++) mhitm[s] = 0;
      for (int l = 0; l < 4; l++) begin
        mfound = 0;
        for (int s = 0; s < NS; s++) begin
          if (mp[l] && !mfound && m_act[s] != 0 && m_lane[s] == l && m_y[s] >= LO && m_y[s] <= HI) begin
            mhitm[s] = 1; mfound = 1; mhits++;
          end
        end
      end
      // descriptor cursor sees the slots as they were before this cycle's update
      m_fd = 0; madv = 0;
      if (m_st == 0) begin
        if (frame_start) begin m_st = 1; m_idx = 0; end
      end else if (m_st == 1) begin
        if (m_act[m_idx] != 0) begin
          m_nx = lane_x(m_lane[m_idx]); m_ny = m_y[m_idx]; m_nc = lane_col(m_lane[m_idx]);
          m_nv = 1; m_st = 2;
        end else madv = 1;
      end else if (note_ready) begin
        m_nv = 0; madv = 1;
      end
      if (madv) begin
        if (m_idx == NS - 1) begin m_fd = 1; m_st = 0; m_idx = 0; end
        else begin m_idx++; m_st = 1; end
      end
      mfree = -1;
      for (int s = NS - 1; s >= 0; s--) if (m_act[s] == 0) mfree = s;
      for (int s = 0; s < NS; s++) begin
        if (mhitm[s] != 0) m_act[s] = 0;
        else if (m_act[s] != 0 && mtick) begin
          m_y[s]++;
          if (m_y[s] > HI) begin m_act[s] = 0; mmiss++; end
        end
      end
      if (spawn_valid && mfree >= 0) begin
        m_act[mfree] = 1; m_lane[mfree] = int'(spawn_lane); m_y[mfree] = 0;
      end
      m_score = (m_score + mhits) % 65536;
      if (mmiss > 0) m_combo = 0;
      else m_combo = (m_combo + mhits > 255) ? 255 : m_combo + mhits;
      m_hit = (mhits > 0); m_miss = (mmiss > 0);
      m_tcnt = mtick ? 0 : m_tcnt + 1;
      m_kp = m_kq; m_kq = key_n;
    end
  end

  always @(negedge clock) begin
    if (m_ok) begin
      chk("spawn_ready", spawn_ready, any_free());
      chk("hit", hit, m_hit);
      chk("miss", miss, m_miss);
      chk("score", score, m_score);
      chk("combo", combo, m_combo);
      chk("note_valid", note_valid, m_nv);
      chk("frame_done", frame_done, m_fd);
      if (m_nv) begin
        chk("note_x", note_x, m_nx);
        chk("note_y", note_y, m_ny);
        chk("note_color", note_color, m_nc);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (any_free() == 0 || m_act.sum() != 0) begin
      if (t >= 800) break;
      step(); t++;
    end
    chk(nm, (t < 800), 1);
  endtask

  initial begin
    int t, nh, first, found, ln, ndesc, nfd, b;
    logic [7:0] sx, sy;
    logic [2:0] sc;
    int lanes6[6] = '{1, 0, 2, 1, 3, 1};

    // reset and idle
    reset = 1'b1; repeat (3) step(); reset = 1'b0;
    repeat (10) step();
    chk("rst_score", score, 0);
    chk("rst_combo", combo, 0);
    chk("rst_spawn_ready", spawn_ready, 1);
    chk("rst_note_valid", note_valid, 0);
    chk("rst_hit_miss", {hit, miss}, 0);

    // lone note in lane 2 falls through and misses
    spawn_valid = 1'b1; spawn_lane = 2'd2; step(); spawn_valid = 1'b0;
    t = 0;
    while (!miss && t < 1000) begin step(); t++; end
    chk("p2_miss_seen", miss, 1);
    chk("p2_miss_time", (t >= 455 && t <= 465), 1);
    chk("p2_score", score, 0);
    chk("p2_combo", combo, 0);

    // lane 0 hit with key held: one hit, two clocks after the edge
    spawn_valid = 1'b1; spawn_lane = 2'd0; step(); spawn_valid = 1'b0;
    t = 0;
    while (!(m_act[0] != 0 && m_y[0] == 108) && t < 1000) begin step(); t++; end
    chk("p3_wait", (t < 1000), 1);
    key_n = 4'b0111; nh = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (hit) begin nh++; if (first < 0) first = i; end
    end
    key_n = 4'hF;
    chk("p3_hits", nh, 1);
    chk("p3_latency", first, 1);
    chk("p3_score", score, 1);
    chk("p3_combo", combo, 1);
    repeat (2) step(); key_n = 4'b0111; repeat (4) step(); key_n = 4'hF; repeat (2) step();
    chk("p3_empty_press_score", score, 1);
    chk("p3_empty_press_combo", combo, 1);

    // fill all slots, reject a 9th, free one by a hit
    for (int i = 0; i < NS; i++) begin
      spawn_valid = 1'b1; spawn_lane = 2'($urandom_range(0, 3)); step();
    end
    chk("p4_full", spawn_ready, 0);
    step(); step(); spawn_valid = 1'b0;
    chk("p4_still_full", spawn_ready, 0);
    t = 0; found = -1;
    while (found < 0 && t < 600) begin
      step(); t++;
      for (int s = 0; s < NS; s++) if (found < 0 && m_act[s] != 0 && m_y[s] >= 107) found = s;
    end
    chk("p4_wait", (found >= 0), 1);
    ln = (found >= 0) ? m_lane[found] : 0;
    key_n = 4'hF; key_n[3-ln] = 1'b0;
    chk("p4_ready_before_hit", spawn_ready, 0);
    t = 0;
    while (!hit && t < 10) begin step(); t++; end
    chk("p4_hit_seen", hit, 1);
    chk("p4_ready_after_hit", spawn_ready, 1);
    key_n = 4'hF;
    drain("p4_drain");
    chk("p4_score", score, 2);
    chk("p4_combo", combo, 0);

    // two lanes hit together on a tick cycle
    t = 0;
    while (m_tcnt != 0 && t < 10) begin step(); t++; end
    spawn_valid = 1'b1; spawn_lane = 2'd1; step();
    spawn_lane = 2'd3; step(); spawn_valid = 1'b0;
    t = 0;
    while (!(m_y[0] == 110 && m_y[1] == 110 && m_tcnt == 2) && t < 1000) begin step(); t++; end
    chk("p5_wait", (t < 1000), 1);
    key_n = 4'b1010; step(); step(); key_n = 4'hF;
    chk("p5_hit", hit, 1);
    chk("p5_score", score, 4);
    chk("p5_combo", combo, 2);
    chk("p5_model_cleared", m_act[0] + m_act[1], 0);

    // slots 0,3,5 live (lane 1), stalled descriptor pass
    for (int i = 0; i < 6; i++) begin
      spawn_valid = 1'b1; spawn_lane = 2'(lanes6[i]); step();
    end
    spawn_valid = 1'b0;
    t = 0;
    while (!(m_y[1] >= LO && m_y[2] >= LO && m_y[4] >= LO) && t < 1000) begin step(); t++; end
    chk("p6_wait", (t < 1000), 1);
    key_n = 4'b0100; step(); step(); key_n = 4'hF;
    chk("p6_hit", hit, 1);
    chk("p6_score", score, 7);
    chk("p6_combo", combo, 5);
    frame_start = 1'b1; step(); frame_start = 1'b0;
    ndesc = 0; nfd = 0; t = 0;
    while (nfd == 0 && t < 300) begin
      if (note_valid) begin
        sx = note_x; sy = note_y; sc = note_color;
        chk("p6_desc_x", sx, 70);
        chk("p6_desc_color", sc, 3'b010);
        for (int k = 0; k < 5; k++) begin
          step();
          chk("p6_hold", {note_valid, note_x, note_y, 5'd0, note_color}, {1'b1, sx, sy, 5'd0, sc});
        end
        note_ready = 1'b1; step(); note_ready = 1'b0;
        ndesc++;
      end else begin
        step();
      end
      if (frame_done) nfd++;
      t++;
    end
    chk("p6_desc_count", ndesc, 3);
    chk("p6_frame_done", nfd, 1);
    nfd = 0;
    for (int i = 0; i < 10; i++) begin step(); if (frame_done) nfd++; end
    chk("p6_single_done", nfd, 0);

    // reset during the second descriptor aborts the pass
    drain("p7_drain");
    spawn_valid = 1'b1; spawn_lane = 2'd3; step(); spawn_lane = 2'd0; step(); spawn_valid = 1'b0;
    frame_start = 1'b1; step(); frame_start = 1'b0;
    t = 0;
    while (!note_valid && t < 20) begin step(); t++; end
    chk("p7_first_valid", note_valid, 1);
    chk("p7_first_x", note_x, 90);
    note_ready = 1'b1; step(); note_ready = 1'b0;
    t = 0;
    while (!note_valid && t < 20) begin step(); t++; end
    chk("p7_second_valid", note_valid, 1);
    chk("p7_second_color", note_color, 3'b100);
    reset = 1'b1; step(); reset = 1'b0;
    chk("p7_valid_dropped", note_valid, 0);
    nfd = 0;
    for (int i = 0; i < 20; i++) begin step(); if (frame_done) nfd++; end
    chk("p7_no_done", nfd, 0);
    chk("p7_score_reset", score, 0);

    // random soak
    for (int i = 0; i < 3000; i++) begin
      spawn_valid = ($urandom_range(0, 9) < 3);
      spawn_lane  = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0) begin b = $urandom_range(0, 3); key_n[b] = ~key_n[b]; end
      frame_start = ($urandom_range(0, 39) == 0);
      note_ready  = ($urandom_range(0, 1) == 1);
      step();
    end
    spawn_valid = 1'b0; frame_start = 1'b0; note_ready = 1'b0; key_n = 4'hF;
    repeat (4) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
